// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD 1-bit DAT block transmitter.
package sd_dat_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PRE    = 4'd1,
    STARTB = 4'd2,
    DATA   = 4'd3,
    CRCB   = 4'd4,
    ENDB   = 4'd5,
    WAITS  = 4'd6,
    TOKEN  = 4'd7,
    BUSYW  = 4'd8,
    FIN    = 4'd9
  } state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_CRC_ERR = 2'd1;
  localparam logic [1:0] ST_WR_ERR  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [2:0] TOK_OK      = 3'b010;
  localparam logic [2:0] TOK_CRC_ERR = 3'b101;
  localparam logic [2:0] TOK_WR_ERR  = 3'b110;

  // Map the three token bits and the token end bit to a status code.
  function automatic logic [1:0] decode_token(input logic [2:0] tok, input logic end_bit);
    logic [1:0] st;
    st = ST_TIMEOUT;
    if (end_bit) begin
      case (tok)
        TOK_OK:      st = ST_OK;
        TOK_CRC_ERR: st = ST_CRC_ERR;
        TOK_WR_ERR:  st = ST_WR_ERR;
        default:     st = ST_TIMEOUT;
      endcase
    end
    return st;
  endfunction

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sd_status_busy_rx.sv
// Receives the card's CRC status token after the end bit and waits out busy.
// arm_i starts a receive; done_o pulses (combinationally, on the deciding
// ClkEn) with status_o valid in the same cycle.
module sd_status_busy_rx
  import sd_dat_pkg::*;
#(
  parameter int unsigned STATUS_TIMEOUT = 64,
  parameter int unsigned BUSY_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en_i,
  input  logic       dat_i,
  input  logic       arm_i,
  output logic       done_o,
  output logic [1:0] status_o,
  output state_e     state_o
);

  localparam logic [15:0] STATUS_LAST = 16'(STATUS_TIMEOUT - 1);
  localparam logic [15:0] BUSY_LAST   = 16'(BUSY_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  tok_q, tok_d;
  logic [1:0]  tcnt_q, tcnt_d;
  logic [1:0]  tstat_q, tstat_d;
  logic [1:0]  tok_st;

  assign state_o = state_q;
  assign tok_st  = decode_token(tok_q, dat_i);

  // Receiver state register and sample counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tok_q   <= '0;
      tcnt_q  <= '0;
      tstat_q <= ST_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
      tcnt_q  <= tcnt_d;
      tstat_q <= tstat_d;
    end
  end

  // Next-state: wait for start bit, shift in token, then wait for DAT0 high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tok_d    = tok_q;
    tcnt_d   = tcnt_q;
    tstat_d  = tstat_q;
    done_o   = 1'b0;
    status_o = tstat_q;
    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = WAITS;
          cnt_d   = '0;
        end
      end
      WAITS: begin
        if (clk_en_i) begin
          if (!dat_i) begin
            state_d = TOKEN;
            tcnt_d  = '0;
            tok_d   = '0;
          end else if (cnt_q == STATUS_LAST) begin
            done_o   = 1'b1;
            status_o = ST_TIMEOUT;
            state_d  = IDLE;
          end else begin
            cnt_d = sat_inc16(cnt_q);
          end
        end
      end
      TOKEN: begin
        if (clk_en_i) begin
          if (tcnt_q != 2'd3) begin
            tok_d  = {tok_q[1:0], dat_i};
            tcnt_d = tcnt_q + 2'd1;
          end else if (tok_st == ST_TIMEOUT) begin
            done_o   = 1'b1;
            status_o = ST_TIMEOUT;
            state_d  = IDLE;
          end else begin
            tstat_d = tok_st;
            cnt_d   = '0;
            state_d = BUSYW;
          end
        end
      end
      BUSYW: begin
        if (clk_en_i) begin
          if (dat_i) begin
            done_o  = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == BUSY_LAST) begin
            done_o   = 1'b1;
            status_o = ST_TIMEOUT;
            state_d  = IDLE;
          end else begin
            cnt_d = sat_inc16(cnt_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/sd_dat_block_tx.sv
// SD 1-bit write-data transmitter: preamble, start bit, block data MSB-first,
// latched CRC16, end bit, then hands DAT0 to the status/busy receiver.
// Request handshake: Start is a one-cycle request that is accepted only when
// the FSM is IDLE and CrcValid is high; Busy high means further requests are
// dropped, Done pulses once per accepted request with Status valid.
module sd_dat_block_tx
  import sd_dat_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned PREAMBLE_BITS  = 2,
  parameter int unsigned STATUS_TIMEOUT = 64,
  parameter int unsigned BUSY_TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ClkEn,
  input  logic        Start,
  input  logic        CrcValid,
  input  logic [15:0] Crc,
  output logic [15:0] ByteAddr,
  input  logic [7:0]  ByteData,
  output logic        DatOut,
  output logic        DatOe,
  input  logic        DatIn,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  Status,
  output state_e      DbgState
);

  localparam logic [18:0] LAST_BIT = 19'(BLOCK_BYTES * 8 - 1);
  localparam logic [15:0] PRE_N    = 16'(PREAMBLE_BITS);

  state_e      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] addr_q, addr_d;
  logic [18:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic        oe_q, oe_d;
  logic [1:0]  status_q, status_d;
  logic        rx_arm, rx_done;
  logic [1:0]  rx_status;
  state_e      rx_state;

  sd_status_busy_rx #(
    .STATUS_TIMEOUT(STATUS_TIMEOUT),
    .BUSY_TIMEOUT  (BUSY_TIMEOUT)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en_i(ClkEn),
    .dat_i   (DatIn),
    .arm_i   (rx_arm),
    .done_o  (rx_done),
    .status_o(rx_status),
    .state_o (rx_state)
  );

  assign ByteAddr = addr_q;
  assign DatOe    = oe_q;
  assign Status   = status_q;
  assign Busy     = (state_q != IDLE) && (state_q != FIN);
  assign Done     = (state_q == FIN);
  assign DbgState = (state_q == WAITS) ? rx_state : state_q;

  // Line value follows the registered state/shift registers only.
  always_comb begin
    DatOut = 1'b1;
    case (state_q)
      STARTB:  DatOut = 1'b0;
      DATA:    DatOut = sh_q[7];
      CRCB:    DatOut = crc_q[15];
      default: DatOut = 1'b1;
    endcase
  end

  // TX state register, shift registers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      pre_cnt_q <= '0;
      oe_q      <= 1'b0;
      status_q  <= ST_OK;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      bit_cnt_q <= bit_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      oe_q      <= oe_d;
      status_q  <= status_d;
    end
  end

  // TX next-state. DatOe rises on the first strobe in PRE so that every
  // preamble bit spans a full ClkEn interval.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    bit_cnt_d = bit_cnt_q;
    pre_cnt_d = pre_cnt_q;
    oe_d      = oe_q;
    status_d  = status_q;
    rx_arm    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && CrcValid) begin
          state_d   = PRE;
          crc_d     = Crc;
          addr_d    = '0;
          bit_cnt_d = '0;
          pre_cnt_d = '0;
          status_d  = ST_OK;
        end
      end
      PRE: begin
        if (ClkEn) begin
          if (pre_cnt_q == PRE_N) begin
            state_d = STARTB;
          end else begin
            pre_cnt_d = pre_cnt_q + 16'd1;
            oe_d      = 1'b1;
          end
        end
      end
      STARTB: begin
        if (ClkEn) begin
          sh_d      = ByteData;
          addr_d    = 16'd1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (ClkEn) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = CRCB;
          end else begin
            bit_cnt_d = bit_cnt_q + 19'd1;
            if (bit_cnt_q[2:0] == 3'd7) begin
              sh_d   = ByteData;
              addr_d = addr_q + 16'd1;
            end else begin
              sh_d = {sh_q[6:0], 1'b0};
            end
          end
        end
      end
      CRCB: begin
        if (ClkEn) begin
          if (bit_cnt_q == 19'd15) begin
            state_d = ENDB;
          end else begin
            crc_d     = {crc_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 19'd1;
          end
        end
      end
      ENDB: begin
        if (ClkEn) begin
          oe_d    = 1'b0;
          rx_arm  = 1'b1;
          state_d = WAITS;
        end
      end
      WAITS: begin
        if (rx_done) begin
          status_d = rx_status;
          state_d  = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_dat_block_tx.sv
// Directed bench for sd_dat_block_tx with a 4-byte block.
module tb_sd_dat_block_tx;
  import sd_dat_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ClkEn;
  logic        Start;
  logic        CrcValid;
  logic [15:0] Crc;
  logic [15:0] ByteAddr;
  logic [7:0]  ByteData;
  logic        DatOut;
  logic        DatOe;
  logic        DatIn;
  logic        Busy;
  logic        Done;
  logic [1:0]  Status;
  state_e      DbgState;

  int total = 0;
  int bad   = 0;
  int div   = 1;

  logic [7:0]  mem [0:3];
  logic [51:0] exp_bits;

  assign ByteData = (ByteAddr < 16'd4) ? mem[ByteAddr[1:0]] : 8'h00;

  sd_dat_block_tx #(
    .BLOCK_BYTES   (4),
    .PREAMBLE_BITS (2),
    .STATUS_TIMEOUT(64),
    .BUSY_TIMEOUT  (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ClkEn   (ClkEn),
    .Start   (Start),
    .CrcValid(CrcValid),
    .Crc     (Crc),
    .ByteAddr(ByteAddr),
    .ByteData(ByteData),
    .DatOut  (DatOut),
    .DatOe   (DatOe),
    .DatIn   (DatIn),
    .Busy    (Busy),
    .Done    (Done),
    .Status  (Status),
    .DbgState(DbgState)
  );

  // clock
  always #5 clk = ~clk;

  task automatic clk_cycle(input logic en);
    ClkEn = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_strobe();
    for (int c = 0; c < div - 1; c++) clk_cycle(1'b0);
    clk_cycle(1'b1);
  endtask

  // Start a frame and check all 52 line bits plus the DatOe drop.
  task automatic send_frame(input bit disturb);
    logic prev;
    logic expb;
    Start = 1'b1; CrcValid = 1'b1; Crc = 16'h1234;
    clk_cycle(1'b0);
    Start = 1'b0;
    total++;
    if (Busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", Busy); end
    prev = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      for (int c = 0; c < div - 1; c++) begin
        clk_cycle(1'b0);
        if (k > 1) begin
          total++;
          if (DatOut !== prev || DatOe !== 1'b1) begin
            bad++; $display("FAIL bit_hold k=%0d: got out=%b oe=%b want out=%b oe=1", k, DatOut, DatOe, prev);
          end
        end
      end
      if (disturb && k == 20) begin Start = 1'b1; Crc = 16'hFFFF; end
      clk_cycle(1'b1);
      Start = 1'b0;
      expb = exp_bits[52 - k];
      total++;
      if (DatOut !== expb || DatOe !== 1'b1) begin
        bad++; $display("FAIL tx_bit k=%0d: got out=%b oe=%b want out=%b oe=1", k, DatOut, DatOe, expb);
      end
      total++;
      if (ByteAddr > 16'd4) begin bad++; $display("FAIL addr_range k=%0d: got %0d want <=4", k, ByteAddr); end
      prev = expb;
    end
    do_strobe();
    Crc = 16'h1234;
    total++;
    if (DatOe !== 1'b0 || DatOut !== 1'b1) begin
      bad++; $display("FAIL oe_drop: got oe=%b out=%b want oe=0 out=1", DatOe, DatOut);
    end
    total++;
    if (ByteAddr !== 16'd4) begin bad++; $display("FAIL addr_end: got %0d want 4", ByteAddr); end
  endtask

  // Drive the card response MSB-first; Done must appear after the last bit.
  task automatic card_reply(input logic [127:0] seq, input int n, input logic [1:0] exp_st);
    for (int i = 0; i < n; i++) begin
      DatIn = seq[n - 1 - i];
      do_strobe();
      if (i < n - 1) begin
        total++;
        if (Done !== 1'b0) begin bad++; $display("FAIL early_done i=%0d: got %b want 0", i, Done); end
      end
    end
    total++;
    if (Done !== 1'b1) begin bad++; $display("FAIL done_pulse: got %b want 1", Done); end
    total++;
    if (Status !== exp_st) begin bad++; $display("FAIL status: got %0d want %0d", Status, exp_st); end
    DatIn = 1'b1;
    clk_cycle(1'b0);
    total++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      bad++; $display("FAIL fin_release: got done=%b busy=%b want 0 0", Done, Busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    total++;
    if (DatOut !== 1'b1 || DatOe !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 ||
        Status !== 2'd0 || ByteAddr !== 16'd0) begin
      bad++; $display("FAIL reset: got out=%b oe=%b busy=%b done=%b st=%0d addr=%0d want 1 0 0 0 0 0",
                      DatOut, DatOe, Busy, Done, Status, ByteAddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clk_cycle(1'b0);
  endtask

  task automatic test_no_crc_valid();
    Start = 1'b1; CrcValid = 1'b0;
    for (int i = 0; i < 3; i++) clk_cycle(1'b1);
    Start = 1'b0; CrcValid = 1'b1;
    total++;
    if (Busy !== 1'b0 || DatOe !== 1'b0 || DbgState !== IDLE) begin
      bad++; $display("FAIL no_crc_valid: got busy=%b oe=%b state=%0d want 0 0 0", Busy, DatOe, DbgState);
    end
  endtask

  task automatic test_ok();
    div = 1;
    send_frame(1'b0);
    card_reply(128'b11001010001, 11, ST_OK);
  endtask

  task automatic test_tokens();
    send_frame(1'b0); card_reply(128'b11010111, 8, ST_CRC_ERR);
    send_frame(1'b0); card_reply(128'b11011011, 8, ST_WR_ERR);
    send_frame(1'b0); card_reply(128'b1101111, 7, ST_TIMEOUT);
    send_frame(1'b0); card_reply(128'b1100100, 7, ST_TIMEOUT);
  endtask

  task automatic test_timeouts();
    send_frame(1'b0);
    card_reply(128'hFFFF_FFFF_FFFF_FFFF, 64, ST_TIMEOUT);
    send_frame(1'b0);
    card_reply({7'b1100101, 16'h0000}, 23, ST_TIMEOUT);
  endtask

  task automatic test_disturb();
    send_frame(1'b1);
    card_reply(128'b11001010001, 11, ST_OK);
  endtask

  task automatic test_clk_div();
    div = 4;
    send_frame(1'b0);
    card_reply(128'b11001010001, 11, ST_OK);
    div = 1;
  endtask

  task automatic test_reset_mid();
    Start = 1'b1; CrcValid = 1'b1; Crc = 16'h1234;
    clk_cycle(1'b0);
    Start = 1'b0;
    for (int k = 0; k < 22; k++) clk_cycle(1'b1);
    total++;
    if (ByteAddr !== 16'd3) begin bad++; $display("FAIL mid_addr: got %0d want 3", ByteAddr); end
    rst_n = 1'b0;
    #1;
    total++;
    if (DatOe !== 1'b0 || DatOut !== 1'b1 || Busy !== 1'b0 || ByteAddr !== 16'd0 || Done !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got oe=%b out=%b busy=%b addr=%0d done=%b want 0 1 0 0 0",
                      DatOe, DatOut, Busy, ByteAddr, Done);
    end
    clk_cycle(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    clk_cycle(1'b0);
    send_frame(1'b0);
    card_reply(128'b11001010001, 11, ST_OK);
  endtask

  initial begin
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
    exp_bits = {3'b110, 32'hA53C00FF, 16'h1234, 1'b1};
    rst_n = 1'b0; ClkEn = 1'b0; Start = 1'b0; CrcValid = 1'b1; Crc = 16'h1234; DatIn = 1'b1;
    test_reset();
    test_no_crc_valid();
    test_ok();
    test_tokens();
    test_timeouts();
    test_disturb();
    test_clk_div();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
